multicycle_core_top: RTL and testbench
======================================

// Module: multicycle_core_top
// PURPOSE
//  Next-generation RV32I-subset core top: replaces the single-cycle PC/IDU/EXU/RF path with a multi-cycle FSM core.
//  Fetches over a valid/ready request channel plus a response channel, so instruction memory may stall.
//  Executes, then writes back; contains its own PC, register file and retirement/halt reporting.
//  Sits between the instruction memory model and the simulation harness (trace/difftest consumers).
// PARAMETERS
//  PC_ADDR     32           PC / fetch address width
//  REG_ADDR    5            register index width; NUM_REGS = 2**REG_ADDR
//  DATA_WIDTH  32           datapath / register width
//  RESET_PC    32'h80000000 PC value loaded on reset
// PORTS
//  clk           in   1           rising-edge clock
//  rst           in   1           synchronous, active-high reset
//  if_req_valid  out  1           fetch request valid
//  if_req_ready  in   1           memory accepts request
//  if_req_addr   out  PC_ADDR     fetch address (= pc_o)
//  if_rsp_valid  in   1           instruction word valid
//  if_rsp_inst   in   DATA_WIDTH  instruction word
//  pc_o          out  PC_ADDR     current PC
//  retire_o      out  1           1-cycle pulse: instruction committed
//  rf_we_o       out  1           register write this cycle (== retire_o && rd!=0 && writes-rd)
//  rf_waddr_o    out  REG_ADDR    write index
//  rf_wdata_o    out  DATA_WIDTH  write data
//  halt_o        out  1           core halted (ebreak)
//  illegal_o     out  1           core halted (unsupported opcode)
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=FETCH, pc_o=RESET_PC, all regs=0.
//   - if_req_valid=0 for the reset cycle; retire_o/rf_we_o/halt_o/illegal_o=0; rf_waddr_o/rf_wdata_o=0.
//   - Reset mid-transaction aborts it; any late if_rsp_valid is ignored until a new request is accepted.
//  States:
//   - FETCH: if_req_valid=1, addr=pc_o. If if_req_ready: -> WAIT. Holds addr/valid stable until accepted.
//   - WAIT: if_req_valid=0. On if_rsp_valid, latch inst into IR -> EXEC; otherwise wait indefinitely.
//   - EXEC: decode IR, read rs1/rs2 (x0 reads 0), compute result and next_pc into regs.
//     - Unsupported opcode -> ILLEGAL.
//     - ebreak -> HALT.
//     - Otherwise -> WB.
//   - WB: retire_o=1; rf_we_o=1 if the instruction writes rd and rd!=0; pc_o<=next_pc -> FETCH.
//   - HALT / ILLEGAL: terminal. halt_o or illegal_o held 1 (set on entry, one cycle after EXEC), no fetches; left only by rst.
//     ebreak and illegal do not pulse retire_o.
//  Latency:
//   - Minimum 4 cycles/instruction (FETCH, WAIT, EXEC, WB) with ready and rsp in the same cycle as the request/wait.
//   - Each stall cycle on ready/rsp adds 1.
//  Supported ops and results:
//   - addi, add, sub, lui, auipc, jal, jalr, ebreak.
//   - Arithmetic is mod 2**DATA_WIDTH, wrap with no flag; I-imm is sign-extended from 12 bits.
//   - jal/jalr: rd <= pc+4.
//   - jalr target = (rs1+imm) & ~1; all other non-jump next_pc = pc+4. PC wraps mod 2**PC_ADDR.
//  Register file:
//   - Written only in WB; reads in EXEC see all prior writes (no forwarding needed).
//   - x0 is never written; rf_waddr_o/rf_wdata_o still report rd and result when rd=0, but rf_we_o=0.
//  Simultaneous events:
//   - if_rsp_valid asserted in FETCH is ignored.
//   - rst overrides all other inputs.
// TESTING
//  1. Reset -> pc_o=32'h80000000, if_req_valid=0 on the reset cycle, then 1 in FETCH; halt_o=illegal_o=retire_o=0.
//  2. addi x1,x0,5 then add x2,x1,x1, zero-wait memory -> retire every 4 cycles; rf_we_o with (1,5) then (2,10); pc_o 0x80000008.
//  3. if_req_ready low 3 cycles, if_rsp_valid delayed 2 cycles -> addr stable while valid; instruction retires at cycle 9; exactly one retire.
//  4. addi x0,x0,7 -> retire_o=1, rf_we_o=0, x0 still reads 0. lui x3,0xFFFFF; addi x3,x3,-1 -> x3=0xFFFFEFFF.
//  5. jalr x1,0(x5) with x5=0x80000011 -> pc_o=0x80000010, x1=old pc+4. ebreak -> halt_o=1 held, no further if_req_valid, no retire.
//  6. Opcode 7'b0000000 -> illegal_o=1 held. rst in WAIT with a response the next cycle -> response ignored, pc_o=RESET_PC, refetch.

Source files
------------

// File: rtl/multicycle_core_top.sv
// multicycle_core_top
//   Multi-cycle RV32I-subset core (addi, add, sub, lui, auipc, jal, jalr, ebreak).
//   Each instruction passes through FETCH -> WAIT -> EXEC -> WB. Instruction
//   memory is reached over a valid/ready request channel and a response channel,
//   so the memory can stall in either phase.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   FETCH   | request valid with addr = pc; leave when the memory accepts
//   WAIT    | request accepted; latch the instruction on if_rsp_valid
//   EXEC    | decode IR, read rs1/rs2, latch result / rd / next_pc
//   WB      | retire; write rd (unless x0); pc <= next_pc
//   HALT    | ebreak seen; terminal until rst
//   ILLEGAL | unsupported encoding seen; terminal until rst
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   if_req_valid/ready/addr     fetch request channel
//   if_rsp_valid/inst           fetch response channel
//   pc_o                        current PC
//   retire_o                    one-cycle commit pulse (WB)
//   rf_we_o/waddr_o/wdata_o     register write report for the retiring instruction
//   halt_o, illegal_o           terminal status flags
module multicycle_core_top #(
    parameter int                  PC_ADDR    = 32,
    parameter int                  REG_ADDR   = 5,
    parameter int                  DATA_WIDTH = 32,
    parameter logic [PC_ADDR-1:0]  RESET_PC   = 32'h80000000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  if_req_valid,
    input  logic                  if_req_ready,
    output logic [PC_ADDR-1:0]    if_req_addr,
    input  logic                  if_rsp_valid,
    input  logic [DATA_WIDTH-1:0] if_rsp_inst,
    output logic [PC_ADDR-1:0]    pc_o,
    output logic                  retire_o,
    output logic                  rf_we_o,
    output logic [REG_ADDR-1:0]   rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  halt_o,
    output logic                  illegal_o
);

    localparam int NUM_REGS = 2 ** REG_ADDR;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    localparam logic [PC_ADDR-1:0] PC_STEP = PC_ADDR'(4);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_WB,
        S_HALT,
        S_ILLEGAL
    } state_t;

    state_t state, state_nxt;

    logic [PC_ADDR-1:0]    pc_q;
    logic [PC_ADDR-1:0]    next_pc_q;
    logic [31:0]           ir_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [REG_ADDR-1:0]   rd_q;
    logic                  wr_rd_q;
    logic [DATA_WIDTH-1:0] rf [NUM_REGS];

    // Decode fields
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_ADDR-1:0]   rs1_idx, rs2_idx, rd_idx;
    logic [31:0]           imm_i, imm_u, imm_j;
    logic [DATA_WIDTH-1:0] rs1_val, rs2_val;

    assign opcode  = ir_q[6:0];
    assign funct3  = ir_q[14:12];
    assign funct7  = ir_q[31:25];
    assign rd_idx  = REG_ADDR'(ir_q[11:7]);
    assign rs1_idx = REG_ADDR'(ir_q[19:15]);
    assign rs2_idx = REG_ADDR'(ir_q[24:20]);
    assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_u   = {ir_q[31:12], 12'b0};
    assign imm_j   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // x0 is never written and resets to zero, so a plain array read returns 0 for it.
    assign rs1_val = rf[rs1_idx];
    assign rs2_val = rf[rs2_idx];

    logic [DATA_WIDTH-1:0] ex_result;
    logic [PC_ADDR-1:0]    ex_next_pc;
    logic [PC_ADDR-1:0]    jalr_sum;
    logic                  ex_wr_rd;
    logic                  ex_illegal;
    logic                  ex_ebreak;

    always_comb begin
        ex_result  = '0;
        ex_next_pc = pc_q + PC_STEP;
        ex_wr_rd   = 1'b0;
        ex_illegal = 1'b0;
        ex_ebreak  = 1'b0;
        jalr_sum   = PC_ADDR'(rs1_val + DATA_WIDTH'(imm_i));
        if (ir_q == INST_EBREAK) begin
            ex_ebreak = 1'b1;
        end else begin
            case (opcode)
                OPC_OP_IMM: begin
                    ex_result  = rs1_val + DATA_WIDTH'(imm_i);
                    ex_wr_rd   = 1'b1;
                    ex_illegal = (funct3 != 3'b000);
                end
                OPC_OP: begin
                    ex_wr_rd = 1'b1;
                    if (funct3 == 3'b000 && funct7 == 7'b0000000)
                        ex_result = rs1_val + rs2_val;
                    else if (funct3 == 3'b000 && funct7 == 7'b0100000)
                        ex_result = rs1_val - rs2_val;
                    else
                        ex_illegal = 1'b1;
                end
                OPC_LUI: begin
                    ex_result = DATA_WIDTH'(imm_u);
                    ex_wr_rd  = 1'b1;
                end
                OPC_AUIPC: begin
                    ex_result = DATA_WIDTH'(pc_q) + DATA_WIDTH'(imm_u);
                    ex_wr_rd  = 1'b1;
                end
                OPC_JAL: begin
                    ex_result  = DATA_WIDTH'(pc_q + PC_STEP);
                    ex_wr_rd   = 1'b1;
                    ex_next_pc = pc_q + PC_ADDR'(imm_j);
                end
                OPC_JALR: begin
                    ex_result  = DATA_WIDTH'(pc_q + PC_STEP);
                    ex_wr_rd   = 1'b1;
                    ex_next_pc = {jalr_sum[PC_ADDR-1:1], 1'b0};
                    ex_illegal = (funct3 != 3'b000);
                end
                default: ex_illegal = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: if (if_req_ready) state_nxt = S_WAIT;
            S_WAIT:  if (if_rsp_valid) state_nxt = S_EXEC;
            S_EXEC: begin
                if (ex_illegal)     state_nxt = S_ILLEGAL;
                else if (ex_ebreak) state_nxt = S_HALT;
                else                state_nxt = S_WB;
            end
            S_WB:      state_nxt = S_FETCH;
            S_HALT:    state_nxt = S_HALT;
            S_ILLEGAL: state_nxt = S_ILLEGAL;
            default:   state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            next_pc_q <= RESET_PC;
            ir_q      <= '0;
            result_q  <= '0;
            rd_q      <= '0;
            wr_rd_q   <= 1'b0;
        end else begin
            case (state)
                S_WAIT: if (if_rsp_valid) ir_q <= if_rsp_inst[31:0];
                S_EXEC: begin
                    result_q  <= ex_result;
                    rd_q      <= rd_idx;
                    wr_rd_q   <= ex_wr_rd;
                    next_pc_q <= ex_next_pc;
                end
                S_WB:    pc_q <= next_pc_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (state == S_WB && wr_rd_q && rd_q != '0) begin
            rf[rd_q] <= result_q;
        end
    end

    // Request is masked during reset so the reset cycle never presents a fetch.
    assign if_req_valid = (state == S_FETCH) && !rst;
    assign if_req_addr  = pc_q;
    assign pc_o         = pc_q;
    assign retire_o     = (state == S_WB);
    assign rf_we_o      = (state == S_WB) && wr_rd_q && (rd_q != '0);
    assign rf_waddr_o   = rd_q;
    assign rf_wdata_o   = result_q;
    assign halt_o       = (state == S_HALT);
    assign illegal_o    = (state == S_ILLEGAL);

endmodule

// File: tb/tb_multicycle_core_top.sv
module tb_multicycle_core_top;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_inst;
    logic [31:0] pc_o;
    logic        retire_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        halt_o;
    logic        illegal_o;

    int n_tests = 0;
    int n_fail  = 0;
    int retire_cnt = 0;
    int cyc;
    int r0;

    multicycle_core_top dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_inst  (if_rsp_inst),
        .pc_o         (pc_o),
        .retire_o     (retire_o),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .halt_o       (halt_o),
        .illegal_o    (illegal_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (retire_o) retire_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] i_type(input logic [6:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, op};
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] u_type(input logic [6:0] op, input logic [4:0] rd,
                                           input logic [19:0] imm);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] j_type(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req_ready = 1'b0;
        if_rsp_valid = 1'b0;
        if_rsp_inst  = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'b0, if_req_valid}, 32'd0);
        chk("rst_pc", pc_o, 32'h80000000);
        chk("rst_flags", {28'b0, retire_o, rf_we_o, halt_o, illegal_o}, 32'd0);
        chk("rst_waddr", {27'b0, rf_waddr_o}, 32'd0);
        chk("rst_wdata", rf_wdata_o, 32'd0);
        rst = 1'b0;
        #1;
        chk("fetch_req_valid", {31'b0, if_req_valid}, 32'd1);
    endtask

    // Starts at a negedge in FETCH; returns at the negedge after EXEC.
    // cyc_out is the 1-based cycle number in which WB (retire) is active.
    task automatic do_instr(input logic [31:0] inst, input logic [31:0] exp_pc,
                            input int rdy_st, input int rsp_st, output int cyc_out);
        int c = 0;
        chk("fetch_addr", if_req_addr, exp_pc);
        chk("fetch_valid", {31'b0, if_req_valid}, 32'd1);
        for (int i = 0; i < rdy_st; i++) begin
            step();
            c++;
            chk("stall_valid", {31'b0, if_req_valid}, 32'd1);
            chk("stall_addr", if_req_addr, exp_pc);
        end
        if_req_ready = 1'b1;
        step();
        c++;
        if_req_ready = 1'b0;
        for (int i = 0; i < rsp_st; i++) begin
            step();
            c++;
        end
        if_rsp_valid = 1'b1;
        if_rsp_inst  = inst;
        step();
        c++;
        if_rsp_valid = 1'b0;
        if_rsp_inst  = '0;
        step();
        c++;
        cyc_out = c + 1;
    endtask

    task automatic expect_wb(input string tag, input logic we, input logic [4:0] wa,
                             input logic [31:0] wd);
        chk({tag, "_retire"}, {31'b0, retire_o}, 32'd1);
        chk({tag, "_we"}, {31'b0, rf_we_o}, {31'b0, we});
        chk({tag, "_waddr"}, {27'b0, rf_waddr_o}, {27'b0, wa});
        chk({tag, "_wdata"}, rf_wdata_o, wd);
        step();
    endtask

    initial begin
        do_reset();

        do_instr(i_type(7'b0010011, 5'd1, 5'd0, 12'd5), 32'h80000000, 0, 0, cyc);
        chk("addi_cycles", cyc, 4);
        expect_wb("addi", 1'b1, 5'd1, 32'd5);

        do_instr(r_type(7'b0000000, 5'd2, 5'd1, 5'd1), 32'h80000004, 0, 0, cyc);
        chk("add_cycles", cyc, 4);
        expect_wb("add", 1'b1, 5'd2, 32'd10);
        chk("pc_after2", pc_o, 32'h80000008);

        r0 = retire_cnt;
        do_instr(i_type(7'b0010011, 5'd3, 5'd0, 12'd1), 32'h80000008, 3, 2, cyc);
        chk("stall_cycles", cyc, 9);
        expect_wb("stall", 1'b1, 5'd3, 32'd1);
        chk("stall_retires", retire_cnt - r0, 1);

        do_instr(i_type(7'b0010011, 5'd0, 5'd0, 12'd7), 32'h8000000C, 0, 0, cyc);
        expect_wb("x0w", 1'b0, 5'd0, 32'd7);
        do_instr(r_type(7'b0000000, 5'd6, 5'd0, 5'd0), 32'h80000010, 0, 0, cyc);
        expect_wb("x0r", 1'b1, 5'd6, 32'd0);

        do_instr(u_type(7'b0110111, 5'd3, 20'hFFFFF), 32'h80000014, 0, 0, cyc);
        expect_wb("lui", 1'b1, 5'd3, 32'hFFFFF000);
        do_instr(i_type(7'b0010011, 5'd3, 5'd3, 12'hFFF), 32'h80000018, 0, 0, cyc);
        expect_wb("addi_neg", 1'b1, 5'd3, 32'hFFFFEFFF);

        do_instr(u_type(7'b0110111, 5'd5, 20'h80000), 32'h8000001C, 0, 0, cyc);
        expect_wb("lui5", 1'b1, 5'd5, 32'h80000000);
        do_instr(i_type(7'b0010011, 5'd5, 5'd5, 12'h011), 32'h80000020, 0, 0, cyc);
        expect_wb("addi5", 1'b1, 5'd5, 32'h80000011);
        do_instr(i_type(7'b1100111, 5'd1, 5'd5, 12'd0), 32'h80000024, 0, 0, cyc);
        expect_wb("jalr", 1'b1, 5'd1, 32'h80000028);
        chk("jalr_pc", pc_o, 32'h80000010);

        do_instr(r_type(7'b0100000, 5'd8, 5'd0, 5'd2), 32'h80000010, 0, 0, cyc);
        expect_wb("sub", 1'b1, 5'd8, 32'hFFFFFFF6);
        do_instr(u_type(7'b0010111, 5'd9, 20'h00001), 32'h80000014, 0, 0, cyc);
        expect_wb("auipc", 1'b1, 5'd9, 32'h80001014);
        do_instr(j_type(5'd10, 21'd8), 32'h80000018, 0, 0, cyc);
        expect_wb("jal", 1'b1, 5'd10, 32'h8000001C);
        chk("jal_pc", pc_o, 32'h80000020);

        r0 = retire_cnt;
        do_instr(32'h00100073, 32'h80000020, 0, 0, cyc);
        chk("ebreak_halt", {31'b0, halt_o}, 32'd1);
        chk("ebreak_ill", {31'b0, illegal_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("halt_held", {30'b0, halt_o, if_req_valid}, 32'd2);
        end
        chk("halt_no_retire", retire_cnt - r0, 0);

        do_reset();
        r0 = retire_cnt;
        do_instr(32'h00000000, 32'h80000000, 0, 0, cyc);
        chk("illegal_flag", {30'b0, illegal_o, halt_o}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("illegal_held", {30'b0, illegal_o, if_req_valid}, 32'd2);
        end
        chk("illegal_no_retire", retire_cnt - r0, 0);

        do_reset();
        do_instr(i_type(7'b0010011, 5'd4, 5'd0, 12'd2), 32'h80000000, 0, 0, cyc);
        expect_wb("pre_abort", 1'b1, 5'd4, 32'd2);
        if_req_ready = 1'b1;
        step();
        if_req_ready = 1'b0;
        chk("abort_in_wait", {31'b0, if_req_valid}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        if_rsp_valid = 1'b1;
        if_rsp_inst  = i_type(7'b0010011, 5'd1, 5'd0, 12'd9);
        #1;
        chk("abort_pc", pc_o, 32'h80000000);
        chk("abort_refetch", {31'b0, if_req_valid}, 32'd1);
        step();
        if_rsp_valid = 1'b0;
        if_rsp_inst  = '0;
        chk("late_rsp_ignored", {30'b0, if_req_valid, retire_o}, 32'd2);
        do_instr(i_type(7'b0010011, 5'd1, 5'd0, 12'd3), 32'h80000000, 0, 0, cyc);
        chk("refetch_cycles", cyc, 4);
        expect_wb("refetch", 1'b1, 5'd1, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
